majority_vote_ctrl: RTL
=======================

// Module: majority_vote_ctrl
// PURPOSE
//  Sequencer for the 5-input majority voter datapath. It opens a voting window on start and
//  collects one vote per voter over independent valid/ack handshakes. The window closes when
//  all five votes are in or a timeout expires; the block then issues the majority decision
//  plus quorum/missing status to one downstream consumer over a valid/ready handshake.
// PARAMETERS
//  N_VOTERS   5    number of voters; fixed at 5 and must stay odd
//  TIMEOUT    16   max cycles spent in COLLECT (>=1)
//  CNT_W      $clog2(TIMEOUT+1)   timeout counter width, derived; do not override
// PORTS
//  clk           in   1  single clock, rising edge
//  rst           in   1  synchronous, active-high reset
//  start         in   1  pulse: open a voting window (honoured only in IDLE)
//  vote_valid    in   5  voter i presents a vote
//  vote_val      in   5  vote value per voter (1 = yes)
//  vote_ack      out  5  voter i's vote accepted this cycle (valid & ack = transfer)
//  busy          out  1  high in every state except IDLE
//  result_valid  out  1  decision available
//  result_ready  in   1  consumer accepts decision
//  result        out  1  majority decision
//  quorum_ok     out  1  at least 3 votes were received
//  missing       out  5  bit i set = voter i did not vote in this window
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): state=IDLE; all outputs 0; got/val registers and timer cleared.
//  FSM states:
//  - IDLE: start=1 -> COLLECT; timer=0; got=0.
//  - COLLECT: vote_ack[i] = ~got[i] (combinational, asserted only here).
//    On vote_valid[i] & vote_ack[i]: got[i]<=1, val[i]<=vote_val[i]. First vote per voter wins.
//    Further vote_valid from a voter already in got is ignored, with no ack.
//    Any subset of voters may transfer in the same cycle.
//    Timer increments each COLLECT cycle.
//    Exit -> DECIDE when (got | accepted-this-cycle) == 5'b11111, or when timer == TIMEOUT-1.
//  - DECIDE (1 cycle): register the decision.
//    result    = popcount(val & got) >= 3. A missing vote counts as 0 (no).
//    quorum_ok = popcount(got) >= 3.
//    missing   = ~got.
//    Then -> DONE.
//  - DONE: result_valid=1. result, quorum_ok and missing are held stable.
//    result_ready=1 -> IDLE next cycle; result_valid drops and result/quorum_ok/missing
//    clear to 0.
//  Latency: start at cycle 0, all votes at cycle 1 -> DECIDE at cycle 2 -> result_valid
//    at cycle 3.
//  Timeout path: DECIDE is entered exactly TIMEOUT cycles after COLLECT entry.
//  start outside IDLE: ignored, with no queuing.
//  vote_valid in IDLE, DECIDE or DONE: no ack and no effect.
//  Votes on the final timeout cycle ARE accepted and count toward the decision.
//  rst mid-window or while result_valid is high: immediate return to IDLE with reset values.
//    The pending decision is discarded.
//  Widths: popcount is 3 bits (0..5). The timer never wraps; it saturates by leaving COLLECT.
// STRUCTURE
//  Package majority_pkg:
//  - state enum {IDLE, COLLECT, DECIDE, DONE} (2-bit encoding)
//  - N_VOTERS = 5, MAJ_THRESH = 3, QUORUM = 3
//  Sub-module popcount5: combinational 5-bit popcount -> 3-bit count.
//    Instantiated twice: once for (val & got), once for got.
//  Everything else lives in one always block for the FSM/registers plus a combinational ack.
// TESTING
//  1. rst held 2 cycles -> busy, result_valid, vote_ack, result, missing all 0.
//     start alone -> busy=1 next cycle.
//  2. start; one cycle later all vote_valid=1, vote_val=5'b10110
//     -> result_valid at +3 cycles, result=1, quorum_ok=1, missing=0.
//  3. start; voters 0,1 vote 1 and voter 2 votes 0, others silent; TIMEOUT=16
//     -> DECIDE 16 cycles after COLLECT entry; result=0, quorum_ok=1, missing=5'b11000.
//  4. Voter 0 sends 1 then 0 in consecutive cycles -> ack on the first only; decision uses 1.
//     vote_valid while IDLE -> vote_ack=0.
//  5. result_ready=0 for 5 cycles in DONE -> result_valid and result stable.
//     start pulsed during DONE is ignored. result_ready=1 -> IDLE, busy=0.
//  6. rst asserted mid-COLLECT after 2 votes -> IDLE next edge.
//     A new window starts with got cleared; missing reflects only the new window.

Source files
------------

// File: rtl/majority_pkg.sv
// Shared types and constants for the 5-input majority vote sequencer.
package majority_pkg;

  localparam int unsigned N_VOTERS   = 5;
  localparam int unsigned MAJ_THRESH = 3;
  localparam int unsigned QUORUM     = 3;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DECIDE,
    DONE
  } state_e;

endpackage

// File: rtl/popcount5.sv
// Combinational population count of a 5-bit vector (result 0..5).
module popcount5 (
  input  logic [4:0] in_i,
  output logic [2:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      count_o = count_o + {2'b00, in_i[i]};
    end
  end

endmodule

// File: rtl/majority_vote_ctrl.sv
// Voting-window sequencer: collects one vote per voter, then presents the
// majority decision with quorum/missing status over a valid/ready handshake.
module majority_vote_ctrl #(
  parameter int unsigned N_VOTERS = 5,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned CNT_W    = $clog2(TIMEOUT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N_VOTERS-1:0] vote_valid,
  input  logic [N_VOTERS-1:0] vote_val,
  output logic [N_VOTERS-1:0] vote_ack,
  output logic                busy,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                result,
  output logic                quorum_ok,
  output logic [N_VOTERS-1:0] missing
);

  import majority_pkg::*;

  state_e              state_q;
  logic [N_VOTERS-1:0] got_q;
  logic [N_VOTERS-1:0] val_q;
  logic [N_VOTERS-1:0] missing_q;
  logic [CNT_W-1:0]    timer_q;
  logic                rvalid_q;
  logic                result_q;
  logic                quorum_q;

  logic [N_VOTERS-1:0] accept;
  logic [2:0]          yes_cnt;
  logic [2:0]          got_cnt;
  logic                all_in;
  logic                timed_out;

  // Ack is offered only to voters that have not yet transferred in this window.
  always_comb begin
    vote_ack = '0;
    if (state_q == COLLECT) begin
      vote_ack = ~got_q;
    end
  end

  assign accept    = vote_valid & vote_ack;
  assign all_in    = &(got_q | accept);
  assign timed_out = (timer_q == CNT_W'(TIMEOUT - 1));

  popcount5 u_pop_yes (
    .in_i    (val_q & got_q),
    .count_o (yes_cnt)
  );

  popcount5 u_pop_got (
    .in_i    (got_q),
    .count_o (got_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      got_q     <= '0;
      val_q     <= '0;
      timer_q   <= '0;
      rvalid_q  <= 1'b0;
      result_q  <= 1'b0;
      quorum_q  <= 1'b0;
      missing_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= COLLECT;
            timer_q <= '0;
            got_q   <= '0;
            val_q   <= '0;
          end
        end
        COLLECT: begin
          got_q   <= got_q | accept;
          val_q   <= (val_q & ~accept) | (vote_val & accept);
          timer_q <= timer_q + CNT_W'(1);
          if (all_in || timed_out) begin
            state_q <= DECIDE;
          end
        end
        DECIDE: begin
          result_q  <= (yes_cnt >= 3'(MAJ_THRESH));
          quorum_q  <= (got_cnt >= 3'(QUORUM));
          missing_q <= ~got_q;
          rvalid_q  <= 1'b1;
          state_q   <= DONE;
        end
        DONE: begin
          if (result_ready) begin
            state_q   <= IDLE;
            rvalid_q  <= 1'b0;
            result_q  <= 1'b0;
            quorum_q  <= 1'b0;
            missing_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = (state_q != IDLE);
  assign result_valid = rvalid_q;
  assign result       = result_q;
  assign quorum_ok    = quorum_q;
  assign missing      = missing_q;

endmodule
